mem_stage: RTL and testbench

// - Memory-access pipeline stage between Execute and Writeback. Holds one instruction whose data-SRAM request
//   was issued in Execute, waits for the data_ok response, aligns/sign-extends load data, and hands the result to Writeback.
// - Buffers a response that arrives while Writeback stalls. Discards responses belonging to flushed instructions.
// - Drives a forwarding/interlock view for Decode.

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_load_align.sv | 28 ++
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the memory-access pipeline stage.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

    localparam logic [7:0] ECODE_ADE = 8'h08;
    localparam logic [7:0] ECODE_ALE = 8'h09;

    // One instruction held by the stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_req;
        logic        is_load;
        logic [2:0]  ld_op;
        logic        ex;
        logic [7:0]  ecode;
    } mem_inst_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (ld_op)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'h0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: waits for the data-SRAM response, buffers it across Writeback
// stalls, and counts responses still owed to flushed instructions so they can be dropped.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        M_allowin,
    input  logic        EM_valid,
    input  logic [31:0] em_pc,
    input  logic [31:0] em_alu_result,
    input  logic        em_gr_we,
    input  logic [4:0]  em_dest,
    input  logic        em_mem_req,
    input  logic        em_is_load,
    input  logic [2:0]  em_ld_op,
    input  logic        em_ex,
    input  logic [7:0]  em_ecode,
    input  logic        data_ok,
    input  logic [31:0] data_rdata,
    input  logic        W_allowin,
    input  logic        ex_en,
    output logic        MW_valid,
    output logic [31:0] mw_pc,
    output logic [31:0] mw_final_result,
    output logic        mw_gr_we,
    output logic [4:0]  mw_dest,
    output logic        mw_ex,
    output logic [7:0]  mw_ecode,
    output logic        m_fwd_we,
    output logic [4:0]  m_fwd_dest,
    output logic [31:0] m_fwd_data,
    output logic        m_fwd_stall
);

    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

    mem_inst_t           inst;
    logic                M_valid;
    logic                rbuf_valid;
    logic [31:0]         rbuf;
    logic [CANCEL_W-1:0] cancel_cnt;

    logic        data_ok_live;
    logic        M_ready_go;
    logic        leave;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] aligned_load;
    logic [31:0] final_result;

    // A response only belongs to the current instruction once all orphaned ones are drained.
    assign data_ok_live = data_ok && (cancel_cnt == '0);
    assign M_ready_go   = !inst.mem_req || inst.ex || rbuf_valid || data_ok_live;
    assign M_allowin    = !M_valid || (M_ready_go && W_allowin);
    assign MW_valid     = M_valid && M_ready_go;
    assign leave        = MW_valid && W_allowin;

    assign cnt_dec = data_ok && (cancel_cnt != '0);
    assign cnt_inc = ex_en && M_valid && inst.mem_req && !inst.ex && !rbuf_valid && !data_ok_live;

    load_align u_load_align (
        .rdata  (rbuf_valid ? rbuf : data_rdata),
        .off    (inst.alu_result[1:0]),
        .ld_op  (inst.ld_op),
        .result (aligned_load)
    );

    assign final_result = (inst.mem_req && inst.is_load && !inst.ex) ? aligned_load : inst.alu_result;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            M_valid <= 1'b0;
            inst    <= '0;
        end else if (ex_en) begin
            M_valid <= 1'b0;
        end else if (M_allowin) begin
            M_valid <= EM_valid;
            if (EM_valid) begin
                inst <= '{pc: em_pc, alu_result: em_alu_result, gr_we: em_gr_we,
                          dest: em_dest, mem_req: em_mem_req, is_load: em_is_load,
                          ld_op: em_ld_op, ex: em_ex, ecode: em_ecode};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rbuf_valid <= 1'b0;
            rbuf       <= '0;
        end else if (ex_en || leave) begin
            rbuf_valid <= 1'b0;
        end else if (M_valid && inst.mem_req && !rbuf_valid && data_ok_live && !W_allowin) begin
            rbuf_valid <= 1'b1;
            rbuf       <= data_rdata;
        end
    end

    // A simultaneous flush and orphan drain leave the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cancel_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            if (cancel_cnt != CNT_MAX) cancel_cnt <= cancel_cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cancel_cnt <= cancel_cnt - 1'b1;
        end
    end

    cancel_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(cnt_inc && !cnt_dec && cancel_cnt == CNT_MAX));

    assign mw_pc           = inst.pc;
    assign mw_final_result = final_result;
    assign mw_gr_we        = M_valid && inst.gr_we;
    assign mw_dest         = inst.dest;
    assign mw_ex           = M_valid && inst.ex;
    assign mw_ecode        = inst.ecode;

    assign m_fwd_we    = M_valid && inst.gr_we && !inst.ex;
    assign m_fwd_dest  = inst.dest;
    assign m_fwd_data  = final_result;
    assign m_fwd_stall = m_fwd_we && inst.is_load && !M_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single instructions plus
// hand-written sequences for buffering, flush cancellation and async reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        M_allowin;
    logic        EM_valid;
    logic [31:0] em_pc;
    logic [31:0] em_alu_result;
    logic        em_gr_we;
    logic [4:0]  em_dest;
    logic        em_mem_req;
    logic        em_is_load;
    logic [2:0]  em_ld_op;
    logic        em_ex;
    logic [7:0]  em_ecode;
    logic        data_ok;
    logic [31:0] data_rdata;
    logic        W_allowin;
    logic        ex_en;
    logic        MW_valid;
    logic [31:0] mw_pc;
    logic [31:0] mw_final_result;
    logic        mw_gr_we;
    logic [4:0]  mw_dest;
    logic        mw_ex;
    logic [7:0]  mw_ecode;
    logic        m_fwd_we;
    logic [4:0]  m_fwd_dest;
    logic [31:0] m_fwd_data;
    logic        m_fwd_stall;

    int errors = 0;
    int checks = 0;

    mem_stage #(.CANCEL_W(2)) dut (
        .clk(clk), .rstn(rstn), .M_allowin(M_allowin), .EM_valid(EM_valid),
        .em_pc(em_pc), .em_alu_result(em_alu_result), .em_gr_we(em_gr_we),
        .em_dest(em_dest), .em_mem_req(em_mem_req), .em_is_load(em_is_load),
        .em_ld_op(em_ld_op), .em_ex(em_ex), .em_ecode(em_ecode),
        .data_ok(data_ok), .data_rdata(data_rdata), .W_allowin(W_allowin),
        .ex_en(ex_en), .MW_valid(MW_valid), .mw_pc(mw_pc),
        .mw_final_result(mw_final_result), .mw_gr_we(mw_gr_we), .mw_dest(mw_dest),
        .mw_ex(mw_ex), .mw_ecode(mw_ecode), .m_fwd_we(m_fwd_we),
        .m_fwd_dest(m_fwd_dest), .m_fwd_data(m_fwd_data), .m_fwd_stall(m_fwd_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_req;
        logic        is_load;
        logic [2:0]  ld_op;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start a new cycle at the falling edge with single-cycle strobes cleared.
    task automatic next();
        @(negedge clk);
        EM_valid = 1'b0;
        data_ok  = 1'b0;
        ex_en    = 1'b0;
    endtask

    task automatic set_em(input logic [31:0] pc, input logic [31:0] alu, input logic mem_req,
                          input logic is_load, input logic [2:0] ld_op, input logic gr_we,
                          input logic ex);
        EM_valid      = 1'b1;
        em_pc         = pc;
        em_alu_result = alu;
        em_mem_req    = mem_req;
        em_is_load    = is_load;
        em_ld_op      = ld_op;
        em_gr_we      = gr_we;
        em_dest       = 5'd7;
        em_ex         = ex;
        em_ecode      = ex ? ECODE_ALE : 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, LD_W,  32'h1234_5678, 32'h0,         32'h1234_5678};
        vecs[1] = '{1'b1, 1'b1, LD_B,  32'h0000_1003, 32'h80FF_FF00, 32'hFFFF_FF80};
        vecs[2] = '{1'b1, 1'b1, LD_HU, 32'h0000_1002, 32'h80FF_FF00, 32'h0000_80FF};
        vecs[3] = '{1'b1, 1'b1, LD_W,  32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b1, LD_BU, 32'h0000_2001, 32'h1234_8A56, 32'h0000_008A};
        vecs[5] = '{1'b1, 1'b1, LD_H,  32'h0000_2000, 32'h1234_8A56, 32'hFFFF_8A56};
        vecs[6] = '{1'b1, 1'b1, LD_B,  32'h0000_2002, 32'h1234_8A56, 32'h0000_0034};
        vecs[7] = '{1'b1, 1'b0, LD_W,  32'h0000_3000, 32'h5555_5555, 32'h0000_3000};

        rstn = 1'b0; EM_valid = 1'b0; em_pc = '0; em_alu_result = '0; em_gr_we = 1'b0;
        em_dest = '0; em_mem_req = 1'b0; em_is_load = 1'b0; em_ld_op = '0; em_ex = 1'b0;
        em_ecode = '0; data_ok = 1'b0; data_rdata = '0; W_allowin = 1'b1; ex_en = 1'b0;

        #2;
        check("reset_mw_valid", {31'b0, MW_valid}, 32'd0);
        check("reset_result", mw_final_result, 32'd0);
        check("reset_fwd_we", {31'b0, m_fwd_we}, 32'd0);
        check("reset_cancel_cnt", {30'b0, dut.cancel_cnt}, 32'd0);
        next();
        rstn = 1'b1;

        // Table: one instruction per entry, W_allowin held high.
        for (int i = 0; i < 8; i++) begin
            next();
            set_em(32'h100 + 32'(i * 4), vecs[i].alu, vecs[i].mem_req, vecs[i].is_load,
                   vecs[i].ld_op, vecs[i].is_load || !vecs[i].mem_req, 1'b0);
            next();
            #1;
            if (vecs[i].mem_req) begin
                check($sformatf("v%0d_wait_valid", i), {31'b0, MW_valid}, 32'd0);
                check($sformatf("v%0d_wait_stall", i), {31'b0, m_fwd_stall}, {31'b0, vecs[i].is_load});
                next();
                data_ok    = 1'b1;
                data_rdata = vecs[i].rdata;
                #1;
            end
            check($sformatf("v%0d_mw_valid", i), {31'b0, MW_valid}, 32'd1);
            check($sformatf("v%0d_result", i), mw_final_result, vecs[i].exp);
            check($sformatf("v%0d_pc", i), mw_pc, 32'h100 + 32'(i * 4));
        end

        // Excepted load leaves in one cycle with the ALU value and no forwarding.
        next();
        set_em(32'h200, 32'h0000_4001, 1'b1, 1'b1, LD_W, 1'b1, 1'b1);
        next();
        #1;
        check("ex_mw_valid", {31'b0, MW_valid}, 32'd1);
        check("ex_result", mw_final_result, 32'h0000_4001);
        check("ex_mw_ex", {31'b0, mw_ex}, 32'd1);
        check("ex_ecode", {24'b0, mw_ecode}, {24'b0, ECODE_ALE});
        check("ex_fwd_we", {31'b0, m_fwd_we}, 32'd0);

        // Response arrives while Writeback stalls for three cycles.
        next();
        set_em(32'h300, 32'h0000_5000, 1'b1, 1'b1, LD_W, 1'b1, 1'b0);
        next();
        W_allowin  = 1'b0;
        data_ok    = 1'b1;
        data_rdata = 32'hCAFE_F00D;
        #1;
        check("rb_c1_allowin", {31'b0, M_allowin}, 32'd0);
        for (int c = 2; c <= 3; c++) begin
            next();
            data_rdata = 32'h0;
            #1;
            check($sformatf("rb_c%0d_rbuf_valid", c), {31'b0, dut.rbuf_valid}, 32'd1);
            check($sformatf("rb_c%0d_result", c), mw_final_result, 32'hCAFE_F00D);
            check($sformatf("rb_c%0d_allowin", c), {31'b0, M_allowin}, 32'd0);
        end
        next();
        W_allowin = 1'b1;
        #1;
        check("rb_rel_valid", {31'b0, MW_valid}, 32'd1);
        check("rb_rel_result", mw_final_result, 32'hCAFE_F00D);
        next();
        #1;
        check("rb_after_rbuf_valid", {31'b0, dut.rbuf_valid}, 32'd0);
        check("rb_after_mw_valid", {31'b0, MW_valid}, 32'd0);

        // Flush while a load waits; its late response must be dropped.
        next();
        set_em(32'h400, 32'h0000_6000, 1'b1, 1'b1, LD_W, 1'b1, 1'b0);
        next();
        #1;
        check("cx_stall", {31'b0, m_fwd_stall}, 32'd1);
        next();
        ex_en = 1'b1;
        next();
        set_em(32'h404, 32'h0000_6004, 1'b1, 1'b1, LD_W, 1'b1, 1'b0);
        #1;
        check("cx_flushed_valid", {31'b0, MW_valid}, 32'd0);
        check("cx_cnt_one", {30'b0, dut.cancel_cnt}, 32'd1);
        next();
        data_ok    = 1'b1;
        data_rdata = 32'h1111_1111;
        #1;
        check("cx_orphan_valid", {31'b0, MW_valid}, 32'd0);
        check("cx_orphan_stall", {31'b0, m_fwd_stall}, 32'd1);
        next();
        #1;
        check("cx_cnt_zero", {30'b0, dut.cancel_cnt}, 32'd0);
        check("cx_still_wait", {31'b0, MW_valid}, 32'd0);
        next();
        data_ok    = 1'b1;
        data_rdata = 32'h2222_2222;
        #1;
        check("cx_own_valid", {31'b0, MW_valid}, 32'd1);
        check("cx_own_result", mw_final_result, 32'h2222_2222);
        check("cx_own_pc", mw_pc, 32'h404);

        // Flush in the same cycle as the response: nothing owed afterwards.
        next();
        set_em(32'h500, 32'h0000_7000, 1'b1, 1'b1, LD_W, 1'b1, 1'b0);
        next();
        data_ok = 1'b1;
        ex_en   = 1'b1;
        next();
        #1;
        check("sx_cnt", {30'b0, dut.cancel_cnt}, 32'd0);
        check("sx_mw_valid", {31'b0, MW_valid}, 32'd0);

        // Flush with the response already buffered: nothing owed afterwards.
        set_em(32'h600, 32'h0000_8000, 1'b1, 1'b1, LD_W, 1'b1, 1'b0);
        next();
        W_allowin  = 1'b0;
        data_ok    = 1'b1;
        data_rdata = 32'h3333_3333;
        next();
        ex_en = 1'b1;
        next();
        W_allowin = 1'b1;
        #1;
        check("bx_cnt", {30'b0, dut.cancel_cnt}, 32'd0);
        check("bx_rbuf_valid", {31'b0, dut.rbuf_valid}, 32'd0);
        check("bx_mw_valid", {31'b0, MW_valid}, 32'd0);

        // Asynchronous reset between clock edges while a load waits.
        set_em(32'h700, 32'h0000_9003, 1'b1, 1'b1, LD_B, 1'b1, 1'b0);
        next();
        #2;
        rstn = 1'b0;
        #1;
        check("ar_mw_valid", {31'b0, MW_valid}, 32'd0);
        check("ar_pc", mw_pc, 32'd0);
        check("ar_result", mw_final_result, 32'd0);
        check("ar_stall", {31'b0, m_fwd_stall}, 32'd0);
        check("ar_fwd_we", {31'b0, m_fwd_we}, 32'd0);
        check("ar_dest", {27'b0, mw_dest}, 32'd0);
        next();
        rstn = 1'b1;
        set_em(32'h800, 32'hABCD_0000, 1'b0, 1'b0, LD_W, 1'b1, 1'b0);
        next();
        #1;
        check("ar_post_valid", {31'b0, MW_valid}, 32'd1);
        check("ar_post_result", mw_final_result, 32'hABCD_0000);
        check("ar_post_fwd_data", m_fwd_data, 32'hABCD_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
